// File: rtl/pe_mac_v2_pkg.sv
// Shared types and the saturating/wrapping adder used by the systolic MAC cell.
package pe_mac_v2_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; w is the result width (w <= 62).
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w,
                                       input logic               sat);
    logic signed [63:0] full_v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] wrap_v;
    sat_res_t           res;
    full_v = a + b;
    max_v  = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v  = -max_v - 64'sd1;
    wrap_v = (full_v <<< (64 - w)) >>> (64 - w);
    if (full_v > max_v) begin
      res.ovf = 1'b1;
      res.sum = sat ? max_v : wrap_v;
    end else if (full_v < min_v) begin
      res.ovf = 1'b1;
      res.sum = sat ? min_v : wrap_v;
    end else begin
      res.ovf = 1'b0;
      res.sum = full_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_mac_v2_fxp_mac_sat.sv
// Combinational fixed-point multiply, floor-shift, fit to psum width, then add.
module fxp_mac_sat
  import pe_mac_v2_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int PSUM_W   = 16,
  parameter int SATURATE = 1
) (
  input  logic signed [DATA_W-1:0] mul_a,
  input  logic signed [DATA_W-1:0] mul_b,
  input  logic signed [PSUM_W-1:0] addend,
  output logic signed [PSUM_W-1:0] prod,
  output logic                     prod_ovf,
  output logic signed [PSUM_W-1:0] sum,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] prod_full_s;
  logic signed [2*DATA_W-1:0] prod_shift_s;
  sat_res_t                   prod_res_s;
  sat_res_t                   add_res_s;
  logic                       sat_mode_s;
  logic                       unused_bits_s;

  assign sat_mode_s = (SATURATE != 0);

  // Product at full width, then fit the product and the sum into PSUM_W.
  always_comb begin
    prod_full_s  = (2*DATA_W)'(mul_a) * (2*DATA_W)'(mul_b);
    prod_shift_s = prod_full_s >>> FRAC_W;
    prod_res_s   = sat_add(64'(prod_shift_s), 64'sd0, PSUM_W, sat_mode_s);
    prod         = prod_res_s.sum[PSUM_W-1:0];
    prod_ovf     = prod_res_s.ovf;
    add_res_s    = sat_add(64'(prod), 64'(addend), PSUM_W, sat_mode_s);
    sum          = add_res_s.sum[PSUM_W-1:0];
    ovf          = prod_ovf | add_res_s.ovf;
  end

  assign unused_bits_s = ^{prod_res_s.sum[63:PSUM_W], add_res_s.sum[63:PSUM_W]};

endmodule

// File: rtl/pe_mac_v2.sv
// Systolic PE: double-buffered tagged weight, WS/OS MAC with sticky status, registered chains.
module pe_mac_v2
  import pe_mac_v2_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int PSUM_W   = 16,
  parameter int TAG_W    = 4,
  parameter int ROW_ID   = 0,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_os,
  input  logic [PSUM_W-1:0] pe_psum_in,
  input  logic              pe_psum_v_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_weight_v_in,
  input  logic [TAG_W-1:0]  pe_weight_tag_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic              pe_valid_in,
  input  logic              pe_switch_in,
  input  logic              pe_drain_in,
  input  logic              pe_sat_clr,
  output logic [PSUM_W-1:0] pe_psum_out,
  output logic              pe_psum_v_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic              pe_weight_v_out,
  output logic [TAG_W-1:0]  pe_weight_tag_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic              pe_drain_out,
  output logic              pe_sat_flag,
  output logic              pe_col_err
);

  pe_mode_e          mode_s;
  logic [DATA_W-1:0] w_active_r;
  logic [DATA_W-1:0] w_shadow_r;
  logic [PSUM_W-1:0] acc_r;
  logic [DATA_W-1:0] w_eff_s;
  logic [PSUM_W-1:0] addend_s;
  logic [PSUM_W-1:0] prod_s;
  logic [PSUM_W-1:0] sum_s;
  logic              prod_ovf_s;
  logic              ovf_s;
  logic              load_hit_s;
  logic              sat_set_s;
  logic              col_set_s;

  assign mode_s     = pe_mode_e'(cfg_os);
  assign load_hit_s = pe_weight_v_in && (pe_weight_tag_in == TAG_W'(ROW_ID));
  // Switch bypasses the shadow so the MAC in the switch cycle already sees the new weight.
  assign w_eff_s    = pe_switch_in ? w_shadow_r : w_active_r;
  assign addend_s   = (mode_s == PE_OS) ? acc_r : pe_psum_in;

  fxp_mac_sat #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .PSUM_W   (PSUM_W),
    .SATURATE (SATURATE)
  ) u_mac (
    .mul_a    (pe_input_in),
    .mul_b    (w_eff_s),
    .addend   (addend_s),
    .prod     (prod_s),
    .prod_ovf (prod_ovf_s),
    .sum      (sum_s),
    .ovf      (ovf_s)
  );

  // Decide which status events fire this cycle.
  always_comb begin
    sat_set_s = 1'b0;
    col_set_s = 1'b0;
    case (mode_s)
      PE_WS: begin
        if (pe_valid_in) begin
          sat_set_s = ovf_s;
        end else begin
          sat_set_s = 1'b0;
        end
      end
      PE_OS: begin
        if (pe_drain_in) begin
          sat_set_s = pe_valid_in & prod_ovf_s;
          col_set_s = pe_psum_v_in;
        end else begin
          sat_set_s = pe_valid_in & ovf_s;
        end
      end
      default: begin
        sat_set_s = 1'b0;
        col_set_s = 1'b0;
      end
    endcase
  end

  // Weight double buffer: switch reads the old shadow before a same-cycle load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_active_r <= {DATA_W{1'b0}};
      w_shadow_r <= {DATA_W{1'b0}};
    end else begin
      if (pe_switch_in) w_active_r <= w_shadow_r;
      if (load_hit_s)   w_shadow_r <= pe_weight_in;
    end
  end

  // Psum output and OS accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_psum_out   <= {PSUM_W{1'b0}};
      pe_psum_v_out <= 1'b0;
      acc_r         <= {PSUM_W{1'b0}};
    end else begin
      case (mode_s)
        PE_WS: begin
          pe_psum_out   <= pe_valid_in ? sum_s : {PSUM_W{1'b0}};
          pe_psum_v_out <= pe_valid_in;
        end
        PE_OS: begin
          if (pe_drain_in) begin
            pe_psum_out   <= acc_r;
            pe_psum_v_out <= 1'b1;
            acc_r         <= pe_valid_in ? prod_s : {PSUM_W{1'b0}};
          end else begin
            if (pe_valid_in) acc_r <= sum_s;
            if (pe_psum_v_in) pe_psum_out <= pe_psum_in;
            pe_psum_v_out <= pe_psum_v_in;
          end
        end
        default: begin
          pe_psum_v_out <= 1'b0;
        end
      endcase
    end
  end

  // Forward chains toward east and south.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_weight_out     <= {DATA_W{1'b0}};
      pe_weight_v_out   <= 1'b0;
      pe_weight_tag_out <= {TAG_W{1'b0}};
      pe_input_out      <= {DATA_W{1'b0}};
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
    end else begin
      pe_weight_out     <= pe_weight_in;
      pe_weight_v_out   <= pe_weight_v_in;
      pe_weight_tag_out <= pe_weight_tag_in;
      pe_valid_out      <= pe_valid_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
      if (pe_valid_in) pe_input_out <= pe_input_in;
    end
  end

  // Sticky flags; a set in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_sat_flag <= 1'b0;
      pe_col_err  <= 1'b0;
    end else begin
      pe_sat_flag <= sat_set_s | (pe_sat_flag & ~pe_sat_clr);
      pe_col_err  <= col_set_s | (pe_col_err & ~pe_sat_clr);
    end
  end

endmodule
